// File: rtl/umi_req_rr_arbiter_if.sv
// Bundles the N host request channels, the merged output channel and the grant counters.
// master: hosts/device side driving requests and out_ready; slave: the arbiter itself.
interface umi_req_rr_arbiter_if #(
  parameter int N  = 5,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]    in_valid;
  logic [N*CW-1:0] in_cmd;
  logic [N*AW-1:0] in_dstaddr;
  logic [N*AW-1:0] in_srcaddr;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]    in_ready;

  logic            out_valid;
  logic [CW-1:0]   out_cmd;
  logic [AW-1:0]   out_dstaddr;
  logic [AW-1:0]   out_srcaddr;
  logic [DW-1:0]   out_data;
  logic [IW-1:0]   out_srcid;
  logic            out_ready;

  logic [N*16-1:0] stat_grants;

  modport master (
    output in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
    input  in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
           out_srcid, stat_grants
  );

  modport slave (
    input  in_valid, in_cmd, in_dstaddr, in_srcaddr, in_data, out_ready,
    output in_ready, out_valid, out_cmd, out_dstaddr, out_srcaddr, out_data,
           out_srcid, stat_grants
  );
endinterface

// File: rtl/umi_req_rr_arbiter.sv
// Round-robin merge of N UMI request channels into one registered, srcid-tagged channel; per-channel grant counters under UMI_ARB_STATS_EN.
// Latency: 1 cycle from input handshake to out_valid; one packet per cycle sustained.
// Backpressure: while out_valid & ~out_ready the payload holds and every in_ready is low.
module umi_req_rr_arbiter #(
  parameter int N  = 5,
  parameter int CW = 32,
  parameter int AW = 64,
  parameter int DW = 256
) (
  input logic                 clk,
  input logic                 nreset,
  umi_req_rr_arbiter_if.slave req
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic          load;
  logic          gnt_vld;
  logic [IW-1:0] gnt_idx;
  logic [N-1:0]  gnt_oh;
  logic          xfer;
  logic [IW-1:0] ptr;
  logic [IW-1:0] ptr_nxt;
  logic [IW-1:0] cand [N];

  logic [CW-1:0] sel_cmd;
  logic [AW-1:0] sel_dstaddr;
  logic [AW-1:0] sel_srcaddr;
  logic [DW-1:0] sel_data;

  assign load = ~req.out_valid | req.out_ready;

  // Walk from the highest offset down so the channel nearest ptr wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < N; k++) begin
      cand[k] = IW'((int'(ptr) + k) % N);
    end
    for (int k = N - 1; k >= 0; k--) begin
      if (req.in_valid[cand[k]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < N; i++) begin
      gnt_oh[i] = gnt_vld && (gnt_idx == IW'(i));
    end
  end

  // nreset gates ready so no channel sees a handshake while the block is held in reset.
  assign xfer         = nreset & load & gnt_vld;
  assign req.in_ready = (nreset & load) ? gnt_oh : '0;
  assign ptr_nxt      = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    sel_cmd     = '0;
    sel_dstaddr = '0;
    sel_srcaddr = '0;
    sel_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_oh[i]) begin
        sel_cmd     = req.in_cmd[i*CW +: CW];
        sel_dstaddr = req.in_dstaddr[i*AW +: AW];
        sel_srcaddr = req.in_srcaddr[i*AW +: AW];
        sel_data    = req.in_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      req.out_valid   <= 1'b0;
      req.out_cmd     <= '0;
      req.out_dstaddr <= '0;
      req.out_srcaddr <= '0;
      req.out_data    <= '0;
      req.out_srcid   <= '0;
      ptr             <= '0;
    end else if (xfer) begin
      req.out_valid   <= 1'b1;
      req.out_cmd     <= sel_cmd;
      req.out_dstaddr <= sel_dstaddr;
      req.out_srcaddr <= sel_srcaddr;
      req.out_data    <= sel_data;
      req.out_srcid   <= gnt_idx;
      ptr             <= ptr_nxt;
    end else if (req.out_valid && req.out_ready) begin
      req.out_valid   <= 1'b0;
    end
  end

`ifdef UMI_ARB_STATS_EN
  logic [15:0] grant_cnt [N];

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) begin
        grant_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (xfer && gnt_oh[i] && (grant_cnt[i] != 16'hFFFF)) begin
          grant_cnt[i] <= grant_cnt[i] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    req.stat_grants = '0;
    for (int i = 0; i < N; i++) begin
      req.stat_grants[i*16 +: 16] = grant_cnt[i];
    end
  end
`else
  assign req.stat_grants = '0;
`endif

  a_ready_onehot : assert property (@(posedge clk) disable iff (!nreset)
    $onehot0(req.in_ready));
  a_ready_needs_valid : assert property (@(posedge clk) disable iff (!nreset)
    (req.in_ready & ~req.in_valid) == '0);

endmodule

// File: tb/tb_umi_req_rr_arbiter.sv
// Directed bench for umi_req_rr_arbiter: vector table for grant order and stalls, hand sequences for reset and counters.
module tb_umi_req_rr_arbiter;
  localparam int N  = 5;
  localparam int CW = 32;
  localparam int AW = 64;
  localparam int DW = 256;

  typedef struct {
    logic [N-1:0] vld;
    logic         ordy;
    logic [N-1:0] exp_rdy;
    logic         exp_ov;
    int           exp_id;
  } vec_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  umi_req_rr_arbiter_if #(.N(N), .CW(CW), .AW(AW), .DW(DW)) bus ();

  umi_req_rr_arbiter #(.N(N), .CW(CW), .AW(AW), .DW(DW)) dut (
    .clk    (clk),
    .nreset (nreset),
    .req    (bus.slave)
  );

  function automatic logic [CW-1:0] cmd_of(int i);
    return 32'hC0DE_0000 | CW'(i);
  endfunction

  function automatic logic [AW-1:0] dst_of(int i);
    return (i == 2) ? 64'h100 : (64'hDA00_0000_0000_0000 | AW'(i));
  endfunction

  function automatic logic [AW-1:0] src_of(int i);
    return 64'h5A00_0000_0000_0000 | (AW'(i) << 8);
  endfunction

  function automatic logic [DW-1:0] data_of(int i);
    return {8{32'hD47A_0000 | 32'(i)}};
  endfunction

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v, string tag);
    @(negedge clk);
    bus.in_valid  = v.vld;
    bus.out_ready = v.ordy;
    #1;
    chk({tag, "_in_ready"}, 256'(bus.in_ready), 256'(v.exp_rdy));
    @(posedge clk);
    #1;
    chk({tag, "_out_valid"}, 256'(bus.out_valid), 256'(v.exp_ov));
    if (v.exp_ov) begin
      chk({tag, "_srcid"}, 256'(bus.out_srcid), 256'(v.exp_id));
      chk({tag, "_cmd"}, 256'(bus.out_cmd), 256'(cmd_of(v.exp_id)));
      chk({tag, "_dstaddr"}, 256'(bus.out_dstaddr), 256'(dst_of(v.exp_id)));
      chk({tag, "_srcaddr"}, 256'(bus.out_srcaddr), 256'(src_of(v.exp_id)));
      chk({tag, "_data"}, 256'(bus.out_data), 256'(data_of(v.exp_id)));
    end
  endtask

  vec_t vt[$];

  initial begin
    // fairness: all valid, strict rotation 0..4
    for (int k = 0; k < 10; k++) begin
      vt.push_back('{5'b11111, 1'b1, N'(1) << (k % N), 1'b1, k % N});
    end
    // ch2 captured, then 4 stalled cycles with everyone valid, then release -> ch3
    vt.push_back('{5'b00100, 1'b1, 5'b00100, 1'b1, 2});
    for (int k = 0; k < 4; k++) begin
      vt.push_back('{5'b11111, 1'b0, 5'b00000, 1'b1, 2});
    end
    vt.push_back('{5'b11111, 1'b1, 5'b01000, 1'b1, 3});
    // ptr=4, only ch1 valid -> ch1, ptr=2
    vt.push_back('{5'b00010, 1'b1, 5'b00010, 1'b1, 1});
    // ch3 moves ptr to 4; then ch4 and ch0 valid -> ch4 first, then ch0
    vt.push_back('{5'b01000, 1'b1, 5'b01000, 1'b1, 3});
    vt.push_back('{5'b10001, 1'b1, 5'b10000, 1'b1, 4});
    vt.push_back('{5'b00001, 1'b1, 5'b00001, 1'b1, 0});
    // idle: output drains, ptr frozen at 1
    vt.push_back('{5'b00000, 1'b1, 5'b00000, 1'b0, 0});
    vt.push_back('{5'b00000, 1'b1, 5'b00000, 1'b0, 0});
    // empty output accepts even with out_ready low; ptr=1 -> ch1
    vt.push_back('{5'b11111, 1'b0, 5'b00010, 1'b1, 1});
    // single valid channel wins regardless of ptr
    vt.push_back('{5'b00001, 1'b1, 5'b00001, 1'b1, 0});
    vt.push_back('{5'b00001, 1'b1, 5'b00001, 1'b1, 0});

    for (int i = 0; i < N; i++) begin
      bus.in_cmd[i*CW +: CW]     = cmd_of(i);
      bus.in_dstaddr[i*AW +: AW] = dst_of(i);
      bus.in_srcaddr[i*AW +: AW] = src_of(i);
      bus.in_data[i*DW +: DW]    = data_of(i);
    end
    bus.in_valid  = 5'b11111;
    bus.out_ready = 1'b0;
    nreset        = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 256'(bus.in_ready), 256'(0));
    chk("rst_out_valid", 256'(bus.out_valid), 256'(0));
    chk("rst_out_cmd", 256'(bus.out_cmd), 256'(0));
    chk("rst_out_data", 256'(bus.out_data), 256'(0));
    chk("rst_out_srcid", 256'(bus.out_srcid), 256'(0));
    chk("rst_stats", 256'(bus.stat_grants), 256'(0));
    nreset = 1'b1;

    for (int i = 0; i < vt.size(); i++) begin
      apply(vt[i], $sformatf("v%0d", i));
    end

    // async reset during a stall: ptr=1 -> ch2 granted, ptr=3, then stall and reset
    apply('{5'b00100, 1'b1, 5'b00100, 1'b1, 2}, "pre_reset");
    @(negedge clk);
    bus.in_valid  = 5'b11111;
    bus.out_ready = 1'b0;
    #2;
    nreset = 1'b0;
    #1;
    chk("async_out_valid", 256'(bus.out_valid), 256'(0));
    chk("async_out_cmd", 256'(bus.out_cmd), 256'(0));
    chk("async_out_srcid", 256'(bus.out_srcid), 256'(0));
    chk("async_in_ready", 256'(bus.in_ready), 256'(0));
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    nreset = 1'b1;
    apply('{5'b11111, 1'b1, 5'b00001, 1'b1, 0}, "post_reset");
    apply('{5'b11111, 1'b1, 5'b00010, 1'b1, 1}, "post_reset2");

`ifdef UMI_ARB_STATS_EN
    @(negedge clk);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    nreset        = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    bus.in_valid = 5'b00001;
    repeat (3) @(negedge clk);
    bus.in_valid = 5'b01000;
    repeat (7) @(negedge clk);
    bus.in_valid = '0;
    @(negedge clk);
    chk("stat_ch0", 256'(bus.stat_grants[0*16 +: 16]), 256'(3));
    chk("stat_ch1", 256'(bus.stat_grants[1*16 +: 16]), 256'(0));
    chk("stat_ch2", 256'(bus.stat_grants[2*16 +: 16]), 256'(0));
    chk("stat_ch3", 256'(bus.stat_grants[3*16 +: 16]), 256'(7));
    chk("stat_ch4", 256'(bus.stat_grants[4*16 +: 16]), 256'(0));
    bus.in_valid = 5'b00010;
    repeat (70000) @(negedge clk);
    bus.in_valid = '0;
    @(negedge clk);
    chk("stat_ch1_sat", 256'(bus.stat_grants[1*16 +: 16]), 256'(16'hFFFF));
    chk("stat_ch0_hold", 256'(bus.stat_grants[0*16 +: 16]), 256'(3));
`else
    @(negedge clk);
    chk("stat_tied_zero", 256'(bus.stat_grants), 256'(0));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
